// File: rtl/fpu_f64_issue_ctrl.sv
// Purpose: issue stage for the FLOAT64 ALU units; latches one op, drives the shared unit interface, captures the result.
// Latency: a unit that is ready at once gives res_valid two cycles after the request cycle; at most TIMEOUT BUSY cycles.
// Backpressure: req_ready only in IDLE without clean; the result is held in RESP until res_ready.
//
// Ports:
//   clk, rst (async active-low), clean (sync flush, forwarded as unit_clean)
//   req_*   : request handshake + target unit, funcSelect, operands
//   unit_*  : shared ALU interface out (start/sel/func/numA/numB/clean), per-unit numC/ready/err in
//   res_*   : result handshake + data, error and timeout flags
//   busy    : controller is not IDLE
module fpu_f64_issue_ctrl #(
    parameter int NUM_UNITS = 4,
    parameter int UNIT_W    = 2,
    parameter int TIMEOUT   = 64,
    parameter int CNT_W     = 7
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clean,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [UNIT_W-1:0]         req_unit,
    input  logic [1:0]                req_func,
    input  logic [63:0]               req_numA,
    input  logic [63:0]               req_numB,
    output logic                      unit_start,
    output logic [UNIT_W-1:0]         unit_sel,
    output logic [1:0]                unit_func,
    output logic [63:0]               unit_numA,
    output logic [63:0]               unit_numB,
    output logic                      unit_clean,
    input  logic [NUM_UNITS*64-1:0]   unit_numC,
    input  logic [NUM_UNITS-1:0]      unit_ready,
    input  logic [NUM_UNITS-1:0]      unit_err,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [63:0]               res_data,
    output logic                      res_error,
    output logic                      res_timeout,
    output logic                      busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;

    // Selected-unit view. A select index with no attached unit leaves
    // selValid low, so nothing is ever indexed out of range.
    logic               selValid;
    logic               selReady;
    logic               selErr;
    logic [63:0]        selData;

    always_comb begin
        selValid = 1'b0;
        selReady = 1'b0;
        selErr   = 1'b0;
        selData  = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            if (unit_sel == UNIT_W'(k)) begin
                selValid = 1'b1;
                selReady = unit_ready[k];
                selErr   = unit_err[k];
                selData  = unit_numC[k*64 +: 64];
            end
        end
    end

    assign req_ready  = (state == IDLE) && !clean;
    assign busy       = (state != IDLE);
    assign unit_clean = clean;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            unit_start  <= 1'b0;
            unit_sel    <= '0;
            unit_func   <= '0;
            unit_numA   <= '0;
            unit_numB   <= '0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            res_error   <= 1'b0;
            res_timeout <= 1'b0;
        end else if (clean) begin
            // Flush drops both the in-flight op and any pending result.
            state      <= IDLE;
            cnt        <= '0;
            unit_start <= 1'b0;
            res_valid  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        unit_sel   <= req_unit;
                        unit_func  <= req_func;
                        unit_numA  <= req_numA;
                        unit_numB  <= req_numB;
                        cnt        <= '0;
                        unit_start <= 1'b1;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    if (!selValid) begin
                        // No such unit: fail immediately instead of waiting for a timeout.
                        res_data    <= '0;
                        res_error   <= 1'b1;
                        res_timeout <= 1'b0;
                        res_valid   <= 1'b1;
                        unit_start  <= 1'b0;
                        state       <= RESP;
                    end else if (selReady) begin
                        res_data    <= selData;
                        res_error   <= selErr;
                        res_timeout <= 1'b0;
                        res_valid   <= 1'b1;
                        unit_start  <= 1'b0;
                        state       <= RESP;
                    end else if (cnt == CNT_LAST) begin
                        res_data    <= '0;
                        res_error   <= 1'b1;
                        res_timeout <= 1'b1;
                        res_valid   <= 1'b1;
                        unit_start  <= 1'b0;
                        state       <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state      <= IDLE;
                    unit_start <= 1'b0;
                    res_valid  <= 1'b0;
                end
            endcase
        end
    end

endmodule
